dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 256x16 data memory between the control unit (master 0) and the program/data loader (master 1).
- Each master makes one read or write per request, with a req/ack handshake.
- The arbiter latches the winning request, drives D_ADDR/D_WR/D_WDATA to the memory, waits out the read latency, then returns read data with a one-cycle ACK.
- Sits between the control unit and data memory, so the loader can fill memory while the CPU sits in CU_INIT/CU_HALT or between its accesses.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_arb2.sv | 25 ++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : transaction sequencer states
//   MID_*       : master IDs as they appear on OWNER
//   DEF_AW/DW   : default address / data widths of the 256x16 data memory
package dmem_arb_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 16;

    localparam logic MID_CU     = 1'b0;
    localparam logic MID_LOADER = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   req[1:0] : request lines, bit i = master i
//   last     : master granted most recently
//   valid    : at least one request present
//   winner   : chosen master; on a tie the one not granted last wins
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = MID_CU;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = MID_LOADER;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the control unit
// (master 0) and the program/data loader (master 1). One access per
// request, req/ack handshake, no pipelining.
//   CLK, RST                       : clock, synchronous active-high reset
//   Mx_REQ/WR/ADDR/WDATA           : master request, held until Mx_ACK
//   Mx_ACK                         : one-cycle completion pulse
//   Mx_RDATA                       : last read data returned to master x
//   D_ADDR/D_WR/D_WDATA, D_RDATA   : memory side
//   BUSY                           : sequencer is not in IDLE
//   OWNER                          : master currently or last granted
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          M0_REQ,
    input  logic          M0_WR,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [DW-1:0] M0_WDATA,
    output logic          M0_ACK,
    output logic [DW-1:0] M0_RDATA,
    input  logic          M1_REQ,
    input  logic          M1_WR,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [DW-1:0] M1_WDATA,
    output logic          M1_ACK,
    output logic [DW-1:0] M1_RDATA,
    output logic [AW-1:0] D_ADDR,
    output logic          D_WR,
    output logic [DW-1:0] D_WDATA,
    input  logic [DW-1:0] D_RDATA,
    output logic          BUSY,
    output logic          OWNER
);

    localparam int CW = 2;

    arb_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [AW-1:0] d_addr_reg, d_addr_next;
    logic          d_wr_reg, d_wr_next;
    logic [DW-1:0] d_wdata_reg, d_wdata_next;
    logic [1:0]    ack_reg, ack_next;
    logic          busy_reg;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic          capture;
    logic          grant_valid;
    logic          grant_id;

    rr_arb2 u_rr (
        .req    ({M1_REQ, M0_REQ}),
        .last   (last_reg),
        .valid  (grant_valid),
        .winner (grant_id)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            d_addr_reg  <= '0;
            d_wr_reg    <= 1'b0;
            d_wdata_reg <= '0;
            ack_reg     <= 2'b00;
            busy_reg    <= 1'b0;
            owner_reg   <= MID_CU;
            last_reg    <= MID_LOADER;   // so the control unit wins the first tie
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            d_addr_reg  <= d_addr_next;
            d_wr_reg    <= d_wr_next;
            d_wdata_reg <= d_wdata_next;
            ack_reg     <= ack_next;
            busy_reg    <= (state_next != IDLE);
            owner_reg   <= owner_next;
            last_reg    <= last_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        d_addr_next  = d_addr_reg;
        d_wr_next    = 1'b0;          // strobe lives only for the ISSUE cycle
        d_wdata_next = d_wdata_reg;
        ack_next     = 2'b00;
        owner_next   = owner_reg;
        last_next    = last_reg;
        capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    d_wr_next    = grant_id ? M1_WR    : M0_WR;
                    d_addr_next  = grant_id ? M1_ADDR  : M0_ADDR;
                    d_wdata_next = grant_id ? M1_WDATA : M0_WDATA;
                    owner_next   = grant_id;
                    last_next    = grant_id;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (d_wr_reg) begin
                    ack_next[owner_reg] = 1'b1;
                    state_next          = RESP;
                end else begin
                    // WAIT spans RD_LAT cycles; data is taken in the last one
                    cnt_next   = CW'(RD_LAT - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    capture             = 1'b1;
                    ack_next[owner_reg] = 1'b1;
                    state_next          = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One read-data holding register per master; only the owner's is loaded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            logic [DW-1:0] rdata_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rdata_reg <= '0;
                end else if (capture && (owner_reg == 1'(gi))) begin
                    rdata_reg <= D_RDATA;
                end
            end
        end
    endgenerate

    assign M0_RDATA = g_rdata[0].rdata_reg;
    assign M1_RDATA = g_rdata[1].rdata_reg;
    assign M0_ACK   = ack_reg[0];
    assign M1_ACK   = ack_reg[1];
    assign D_ADDR   = d_addr_reg;
    assign D_WR     = d_wr_reg;
    assign D_WDATA  = d_wdata_reg;
    assign BUSY     = busy_reg;
    assign OWNER    = owner_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 with RD_LAT=1, instance 1 with RD_LAT=3,
// each in front of its own behavioural memory. A transaction-level reference
// predicts grant order, ACK cycle, issue cycle and returned data.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [3:0]  gap;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        req_r   [2][2];
    logic        wr_r    [2][2];
    logic [7:0]  addr_r  [2][2];
    logic [15:0] wdata_r [2][2];
    wire         ack_w   [2][2];
    wire  [15:0] rdata_w [2][2];
    wire  [7:0]  d_addr  [2];
    wire         d_wr    [2];
    wire  [15:0] d_wdata [2];
    wire  [15:0] d_rdata [2];
    wire         busy    [2];
    wire         owner   [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ref_mem   [2][256];
    logic [15:0] ref_rdata [2][2];
    logic        ref_last  [2];
    logic        ref_owner [2];
    op_t         ops       [2][16];
    int          n_ops     [2];
    int          op_idx    [2];
    int          grant_log [$];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [15:0] mem  [256];
        logic [15:0] pipe [4];

        initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;

        always @(posedge clk) begin
            if (d_wr[gi]) mem[d_addr[gi]] <= d_wdata[gi];
            pipe[0] <= mem[d_addr[gi]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign d_rdata[gi] = pipe[LAT-1];

        dmem_arbiter #(.AW(8), .DW(16), .RD_LAT(LAT)) u_dut (
            .CLK      (clk),
            .RST      (rst[gi]),
            .M0_REQ   (req_r[gi][0]),
            .M0_WR    (wr_r[gi][0]),
            .M0_ADDR  (addr_r[gi][0]),
            .M0_WDATA (wdata_r[gi][0]),
            .M0_ACK   (ack_w[gi][0]),
            .M0_RDATA (rdata_w[gi][0]),
            .M1_REQ   (req_r[gi][1]),
            .M1_WR    (wr_r[gi][1]),
            .M1_ADDR  (addr_r[gi][1]),
            .M1_WDATA (wdata_r[gi][1]),
            .M1_ACK   (ack_w[gi][1]),
            .M1_RDATA (rdata_w[gi][1]),
            .D_ADDR   (d_addr[gi]),
            .D_WR     (d_wr[gi]),
            .D_WDATA  (d_wdata[gi]),
            .D_RDATA  (d_rdata[gi]),
            .BUSY     (busy[gi]),
            .OWNER    (owner[gi])
        );
    end

    task automatic set_op(input int m, input int i, input logic wr, input logic [7:0] a,
                          input logic [15:0] d, input logic [3:0] gap);
        ops[m][i] = '{wr: wr, addr: a, wdata: d, gap: gap};
    endtask

    task automatic ref_reset(input int inst);
        ref_last[inst]  = 1'b1;
        ref_owner[inst] = 1'b0;
        for (int m = 0; m < 2; m++) ref_rdata[inst][m] = 16'h0;
    endtask

    // Drives ops[][] into one instance and checks every cycle against the
    // transaction-level reference until all ops are acknowledged.
    task automatic run_ops(input int inst, input int budget);
        int lat, c, start, ack_at, own, free_at;
        bit tr_open, done;
        bit active [2];
        int raise_at [2];
        op_t cur;
        logic [15:0] rd_val;
        logic exp_ack, exp_busy;
        lat = (inst == 0) ? 1 : 3;
        tr_open = 0; done = 0; start = 0; ack_at = 0; own = 0; free_at = 0;
        cur = '0; rd_val = '0;
        for (int m = 0; m < 2; m++) begin active[m] = 0; raise_at[m] = 0; op_idx[m] = 0; end
        for (c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (tr_open && c == ack_at && !cur.wr) ref_rdata[inst][own] = rd_val;
            for (int m = 0; m < 2; m++) begin
                exp_ack = tr_open && c == ack_at && own == m;
                n_checks++;
                if (ack_w[inst][m] !== exp_ack) begin
                    n_errors++;
                    $display("FAIL ack inst%0d m%0d cycle %0d: got %b want %b", inst, m, c, ack_w[inst][m], exp_ack);
                end
                n_checks++;
                if (rdata_w[inst][m] !== ref_rdata[inst][m]) begin
                    n_errors++;
                    $display("FAIL rdata inst%0d m%0d cycle %0d: got %h want %h", inst, m, c, rdata_w[inst][m], ref_rdata[inst][m]);
                end
            end
            n_checks++;
            if (tr_open && c == start + 1) begin
                if (d_wr[inst] !== cur.wr || d_addr[inst] !== cur.addr ||
                    (cur.wr && d_wdata[inst] !== cur.wdata)) begin
                    n_errors++;
                    $display("FAIL issue inst%0d cycle %0d: got wr %b addr %h wdata %h want wr %b addr %h wdata %h",
                             inst, c, d_wr[inst], d_addr[inst], d_wdata[inst], cur.wr, cur.addr, cur.wdata);
                end
            end else if (d_wr[inst] !== 1'b0) begin
                n_errors++;
                $display("FAIL strobe inst%0d cycle %0d: got D_WR %b want 0", inst, c, d_wr[inst]);
            end
            exp_busy = tr_open && c > start && c <= ack_at;
            n_checks++;
            if (busy[inst] !== exp_busy) begin
                n_errors++;
                $display("FAIL busy inst%0d cycle %0d: got %b want %b", inst, c, busy[inst], exp_busy);
            end
            n_checks++;
            if (owner[inst] !== ref_owner[inst]) begin
                n_errors++;
                $display("FAIL owner inst%0d cycle %0d: got %b want %b", inst, c, owner[inst], ref_owner[inst]);
            end
            if (tr_open && c == ack_at) begin
                $display("txn inst%0d m%0d %s addr %h data %h ack cycle %0d", inst, own,
                         cur.wr ? "WR" : "RD", cur.addr, cur.wr ? cur.wdata : rd_val, c);
                req_r[inst][own] = 1'b0;
                active[own]      = 0;
                op_idx[own]++;
                raise_at[own]    = c + int'(cur.gap);
                tr_open          = 0;
                free_at          = c + 1;
            end
            // Inputs after the grant must have no effect.
            if (tr_open && c == start + 1) begin
                wr_r[inst][own]    = ~wr_r[inst][own];
                addr_r[inst][own]  = addr_r[inst][own] ^ 8'h10;
                wdata_r[inst][own] = ~wdata_r[inst][own];
            end
            for (int m = 0; m < 2; m++) begin
                if (!active[m] && op_idx[m] < n_ops[m] && c >= raise_at[m]) begin
                    req_r[inst][m]   = 1'b1;
                    wr_r[inst][m]    = ops[m][op_idx[m]].wr;
                    addr_r[inst][m]  = ops[m][op_idx[m]].addr;
                    wdata_r[inst][m] = ops[m][op_idx[m]].wdata;
                    active[m]        = 1;
                end
            end
            if (!tr_open && c >= free_at && (active[0] || active[1])) begin
                if (active[0] && active[1]) own = ref_last[inst] ? 0 : 1;
                else                        own = active[1] ? 1 : 0;
                cur     = ops[own][op_idx[own]];
                start   = c;
                ack_at  = c + 2 + (cur.wr ? 0 : lat);
                tr_open = 1;
                ref_last[inst]  = own[0];
                ref_owner[inst] = own[0];
                grant_log.push_back(own);
                if (cur.wr) ref_mem[inst][cur.addr] = cur.wdata;
                else        rd_val = ref_mem[inst][cur.addr];
            end
            done = !tr_open && op_idx[0] >= n_ops[0] && op_idx[1] >= n_ops[1];
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL timeout inst%0d: got %0d/%0d ops done want all", inst, op_idx[0] + op_idx[1], n_ops[0] + n_ops[1]);
        end
    endtask

    task automatic test_reset(input int inst);
        @(negedge clk);
        rst[inst] = 1'b1;
        for (int m = 0; m < 2; m++) req_r[inst][m] = 1'b0;
        repeat (2) @(negedge clk);
        rst[inst] = 1'b0;
        ref_reset(inst);
        @(negedge clk);
        n_checks++;
        if (ack_w[inst][0] !== 1'b0 || ack_w[inst][1] !== 1'b0 || rdata_w[inst][0] !== 16'h0 ||
            rdata_w[inst][1] !== 16'h0 || d_wr[inst] !== 1'b0 || d_addr[inst] !== 8'h0 ||
            d_wdata[inst] !== 16'h0 || busy[inst] !== 1'b0 || owner[inst] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset inst%0d: got ack %b%b rd %h/%h wr %b addr %h wd %h busy %b own %b want all 0",
                     inst, ack_w[inst][1], ack_w[inst][0], rdata_w[inst][0], rdata_w[inst][1],
                     d_wr[inst], d_addr[inst], d_wdata[inst], busy[inst], owner[inst]);
        end
    endtask

    task automatic test_write_read();
        n_ops[0] = 1; n_ops[1] = 0;
        set_op(0, 0, 1'b1, 8'h10, 16'hBEEF, 4'd0);
        run_ops(0, 50);
        n_ops[0] = 0; n_ops[1] = 1;
        set_op(1, 0, 1'b0, 8'h10, 16'h0, 4'd0);
        run_ops(0, 50);
        n_checks++;
        if (ref_rdata[0][1] !== 16'hBEEF || rdata_w[0][1] !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL read_back: got %h want BEEF", rdata_w[0][1]);
        end
    endtask

    task automatic test_contention();
        test_reset(0);
        grant_log.delete();
        n_ops[0] = 2; n_ops[1] = 2;
        set_op(0, 0, 1'b1, 8'h40, 16'h1111, 4'd0);
        set_op(0, 1, 1'b0, 8'h10, 16'h0,    4'd0);
        set_op(1, 0, 1'b1, 8'h41, 16'h2222, 4'd0);
        set_op(1, 1, 1'b0, 8'h40, 16'h0,    4'd0);
        run_ops(0, 100);
        n_checks++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 ||
            grant_log[2] != 0 || grant_log[3] != 1) begin
            n_errors++;
            $display("FAIL grant_order: got %p want 0,1,0,1", grant_log);
        end
    endtask

    task automatic test_addr_change();
        n_ops[0] = 3; n_ops[1] = 0;
        set_op(0, 0, 1'b1, 8'h20, 16'hA5A5, 4'd1);
        set_op(0, 1, 1'b0, 8'h30, 16'h0,    4'd1);
        set_op(0, 2, 1'b0, 8'h20, 16'h0,    4'd0);
        run_ops(0, 100);
        n_checks++;
        if (rdata_w[0][0] !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL addr_change: got %h want A5A5", rdata_w[0][0]);
        end
    endtask

    task automatic test_rdlat3();
        n_ops[0] = 2; n_ops[1] = 0;
        set_op(0, 0, 1'b1, 8'h05, 16'h1234, 4'd2);
        set_op(0, 1, 1'b0, 8'h05, 16'h0,    4'd0);
        run_ops(1, 100);
        n_checks++;
        if (rdata_w[1][0] !== 16'h1234) begin
            n_errors++;
            $display("FAIL rdlat3: got %h want 1234", rdata_w[1][0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  a;
        logic [15:0] d;
        a = 8'($urandom_range(0, 255));
        d = 16'($urandom);
        @(negedge clk);                                    // cycle t: M1 read
        req_r[0][1] = 1'b1; wr_r[0][1] = 1'b0; addr_r[0][1] = 8'h10;
        @(negedge clk);                                    // ISSUE
        @(negedge clk);                                    // WAIT
        n_checks++;
        if (busy[0] !== 1'b1 || ack_w[0][1] !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_wait: got busy %b ack %b want 1 0", busy[0], ack_w[0][1]);
        end
        rst[0] = 1'b1;
        req_r[0][1] = 1'b0;
        req_r[0][0] = 1'b1; wr_r[0][0] = 1'b1; addr_r[0][0] = a; wdata_r[0][0] = d;
        @(negedge clk);
        n_checks++;
        if (ack_w[0][1] !== 1'b0 || busy[0] !== 1'b0 || rdata_w[0][1] !== 16'h0 || rdata_w[0][0] !== 16'h0) begin
            n_errors++;
            $display("FAIL mid_abort: got ack %b busy %b rd1 %h rd0 %h want 0 0 0000 0000",
                     ack_w[0][1], busy[0], rdata_w[0][1], rdata_w[0][0]);
        end
        rst[0] = 1'b0;
        ref_reset(0);
        @(negedge clk);                                    // ISSUE of M0 write
        n_checks++;
        if (d_wr[0] !== 1'b1 || d_addr[0] !== a || d_wdata[0] !== d || ack_w[0][0] !== 1'b0) begin
            n_errors++;
            $display("FAIL post_rst_issue: got wr %b addr %h wd %h ack %b want 1 %h %h 0",
                     d_wr[0], d_addr[0], d_wdata[0], ack_w[0][0], a, d);
        end
        @(negedge clk);
        n_checks++;
        if (ack_w[0][0] !== 1'b1 || ack_w[0][1] !== 1'b0 || owner[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL post_rst_ack: got ack %b%b owner %b want 01 0", ack_w[0][1], ack_w[0][0], owner[0]);
        end
        $display("txn inst0 m0 WR addr %h data %h after reset", a, d);
        req_r[0][0] = 1'b0;
        ref_mem[0][a]  = d;
        ref_last[0]    = 1'b0;
        ref_owner[0]   = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack_w[0][0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL post_rst_idle: got ack %b busy %b want 0 0", ack_w[0][0], busy[0]);
        end
    endtask

    task automatic test_random(input int inst);
        for (int m = 0; m < 2; m++) begin
            n_ops[m] = 8 + int'($urandom_range(0, 4));
            for (int i = 0; i < n_ops[m]; i++)
                set_op(m, i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                       16'($urandom), 4'($urandom_range(0, 3)));
        end
        run_ops(inst, 2000);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            for (int m = 0; m < 2; m++) begin
                req_r[i][m] = 1'b0; wr_r[i][m] = 1'b0; addr_r[i][m] = 8'h0; wdata_r[i][m] = 16'h0;
            end
            for (int a = 0; a < 256; a++) ref_mem[i][a] = 16'h0;
            ref_reset(i);
        end
        test_reset(0);
        test_reset(1);
        test_write_read();
        test_contention();
        test_addr_change();
        test_rdlat3();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
